// File: rtl/urf_access_ctrl.sv
// urf_access_ctrl: valid/ready request front-end sequencing commands onto the register array.
// Optional feature macro: URF_ADDR_CHECK_EN (reject addresses >= DEPTH).
module urf_access_ctrl #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  arr_write_en,
  output logic [DEPTH-1:0]      arr_write_addr,
  output logic [DATA_WIDTH-1:0] arr_write_data,
  output logic [DEPTH-1:0]      arr_read_addr,
  input  logic [DATA_WIDTH-1:0] arr_read_data,
  input  logic                  arr_busy
);

  localparam int PAD_W = DEPTH - ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RSP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  drop_q, drop_d;
  logic                  err_q, err_d;
  logic                  addr_oor;
  logic [DEPTH-1:0]      addr_ext;
  logic                  unused_busy;

  assign unused_busy = arr_busy;

`ifdef URF_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  assign addr_oor = ({1'b0, req_addr} >= DEPTH_L);
`else
  assign addr_oor = 1'b0;
`endif

  assign addr_ext = {{PAD_W{1'b0}}, addr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    drop_d     = drop_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          drop_d = addr_oor;
          err_d  = 1'b0;
          if (req_we) begin
            wdata_d = req_wdata;
            state_d = S_WR;
          end else if (addr_oor) begin
            rsp_data_d = '0;
            err_d      = 1'b1;
            state_d    = S_RSP;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_WR: begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // the array never reads entry 0, so its read data is stale there
        rsp_data_d = (addr_q == '0) ? '0 : arr_read_data;
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_data_d = '0;
          err_d      = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    arr_write_en   = 1'b0;
    arr_write_addr = '0;
    arr_write_data = '0;
    arr_read_addr  = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = ~rst;
      end
      S_WR: begin
        if (!drop_q) begin
          arr_write_en   = 1'b1;
          arr_write_addr = addr_ext;
          arr_write_data = wdata_q;
        end
      end
      S_RD_ISSUE,
      S_RD_WAIT: begin
        arr_read_addr = addr_ext;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = err_q & rsp_valid;

endmodule

// File: tb/tb_urf_access_ctrl.sv
// tb_urf_access_ctrl: directed bench for urf_access_ctrl with a behavioural register array.
// Define URF_ADDR_CHECK_EN to build with DEPTH=12 and run the address-check scenario.
module tb_urf_access_ctrl;

  localparam int DW = 8;
`ifdef URF_ADDR_CHECK_EN
  localparam int DEPTH = 12;
`else
  localparam int DEPTH = 16;
`endif
  localparam int AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          arr_write_en;
  logic [DEPTH-1:0] arr_write_addr;
  logic [DW-1:0] arr_write_data;
  logic [DEPTH-1:0] arr_read_addr;
  logic [DW-1:0] arr_read_data;
  logic          arr_busy;

  int vectors = 0;
  int miscompares = 0;
  int wr_pulses = 0;

  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  logic [DW-1:0] rd_q = '0;

  always #5 clk = ~clk;

  urf_access_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .arr_write_en(arr_write_en), .arr_write_addr(arr_write_addr),
    .arr_write_data(arr_write_data), .arr_read_addr(arr_read_addr),
    .arr_read_data(arr_read_data), .arr_busy(arr_busy)
  );

  // array model: registered read, only on nonzero read address
  always @(posedge clk) begin
    if (arr_write_en) begin
      mem[arr_write_addr[AW-1:0]] <= arr_write_data;
      wr_pulses <= wr_pulses + 1;
    end
    if (arr_read_addr != '0) rd_q <= mem[arr_read_addr[AW-1:0]];
  end
  assign arr_read_data = rd_q;
  assign arr_busy = 1'b0;

  task automatic wait_idle();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_idle: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_idle();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    vectors++;
    if (arr_write_en !== 1'b1 || arr_write_addr !== DEPTH'(a) ||
        arr_write_data !== d || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL write_slot a=%0d: en=%b addr=%h data=%h rdy=%b required 1/%h/%h/0",
               a, arr_write_en, arr_write_addr, arr_write_data, req_ready, DEPTH'(a), d);
    end
    @(posedge clk); #1;
    vectors++;
    if (arr_write_en !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL write_done a=%0d: en=%b rdy=%b required 0/1", a, arr_write_en, req_ready);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    wait_idle();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '0;
    vectors++;
    if (arr_read_addr !== DEPTH'(a) || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_issue a=%0d: raddr=%h vld=%b rdy=%b required %h/0/0",
               a, arr_read_addr, rsp_valid, req_ready, DEPTH'(a));
    end
    @(posedge clk); #1;
    vectors++;
    if (arr_read_addr !== DEPTH'(a) || rsp_valid !== 1'b0 || arr_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_wait a=%0d: raddr=%h vld=%b wen=%b required %h/0/0",
               a, arr_read_addr, rsp_valid, arr_write_en, DEPTH'(a));
    end
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_err !== 1'b0 || arr_read_addr !== '0) begin
      miscompares++;
      $display("FAIL rd_rsp a=%0d: vld=%b data=%h err=%b raddr=%h required 1/%h/0/0",
               a, rsp_valid, rsp_data, rsp_err, arr_read_addr, e);
    end
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_done a=%0d: vld=%b rdy=%b required 0/1", a, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, arr_write_en, arr_write_addr,
         arr_write_data, arr_read_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h err=%b wen=%b required all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, arr_write_en);
    end
    rst = 1'b0; #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(6); rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (arr_read_addr !== DEPTH'(6)) begin
      miscompares++;
      $display("FAIL mid_read_setup: raddr=%h required %h", arr_read_addr, DEPTH'(6));
    end
    rst = 1'b1; #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, arr_write_en, arr_write_addr,
         arr_write_data, arr_read_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_read: rdy=%b vld=%b raddr=%h required all 0",
               req_ready, rsp_valid, arr_read_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_read_release: rdy=%b vld=%b required 1/0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(9); req_wdata = 8'h99;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b1; #1;
    vectors++;
    if (arr_write_en !== 1'b0 || arr_write_addr !== '0 || arr_write_data !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_write: wen=%b addr=%h data=%h required 0/0/0",
               arr_write_en, arr_write_addr, arr_write_data);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    do_read(AW'(9), 8'h00);
  endtask

  task automatic test_write_read();
    int w0;
    w0 = wr_pulses;
    do_write(AW'(5), 8'hA5);
    vectors++;
    if (wr_pulses !== w0 + 1) begin
      miscompares++;
      $display("FAIL write_pulse_count: pulses=%0d required %0d", wr_pulses - w0, 1);
    end
    do_read(AW'(5), 8'hA5);
  endtask

  task automatic test_backpressure();
    int w0;
    do_write(AW'(3), 8'h3C);
    w0 = wr_pulses;
    wait_idle();
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(3); rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || req_ready !== 1'b0 ||
          arr_write_en !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure cyc=%0d: vld=%b data=%h rdy=%b wen=%b required 1/3c/0/0",
                 i, rsp_valid, rsp_data, req_ready, arr_write_en);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wr_pulses !== w0) begin
      miscompares++;
      $display("FAIL backpressure_release: vld=%b rdy=%b extra_writes=%0d required 0/1/0",
               rsp_valid, req_ready, wr_pulses - w0);
    end
    do_read(AW'(3), 8'h3C);
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_pulses;
    wait_idle();
    req_valid = 1'b1; req_we = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      req_addr = AW'(i); req_wdata = DW'(i);
      @(posedge clk); #1;
      vectors++;
      if (arr_write_en !== 1'b1 || arr_write_addr !== DEPTH'(i) ||
          arr_write_data !== DW'(i) || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_accept i=%0d: wen=%b addr=%h data=%h rdy=%b required 1/%h/%h/0",
                 i, arr_write_en, arr_write_addr, arr_write_data, req_ready, DEPTH'(i), DW'(i));
      end
      req_addr = AW'(i + 1); req_wdata = DW'(i + 1);
      if (i == DEPTH - 1) req_valid = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (arr_write_en !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_gap i=%0d: wen=%b rdy=%b required 0/1", i, arr_write_en, req_ready);
      end
    end
    req_we = 1'b0; req_addr = '0; req_wdata = '0;
    vectors++;
    if (wr_pulses !== w0 + DEPTH - 1) begin
      miscompares++;
      $display("FAIL b2b_count: pulses=%0d required %0d", wr_pulses - w0, DEPTH - 1);
    end
    for (int i = 1; i < DEPTH; i++) do_read(AW'(i), DW'(i));
  endtask

  task automatic test_addr_zero();
    do_write(AW'(0), 8'h5E);
    do_read(AW'(0), 8'h00);
  endtask

`ifdef URF_ADDR_CHECK_EN
  task automatic test_addr_check();
    int w0;
    wait_idle();
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(13); rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || arr_read_addr !== '0) begin
      miscompares++;
      $display("FAIL oor_read: vld=%b err=%b data=%h raddr=%h required 1/1/0/0",
               rsp_valid, rsp_err, rsp_data, arr_read_addr);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_read_done: vld=%b err=%b rdy=%b required 0/0/1",
               rsp_valid, rsp_err, req_ready);
    end
    w0 = wr_pulses;
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(14); req_wdata = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    vectors++;
    if (arr_write_en !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_write_slot: wen=%b rdy=%b required 0/0", arr_write_en, req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || wr_pulses !== w0) begin
      miscompares++;
      $display("FAIL oor_write_done: rdy=%b writes=%0d required 1/0", req_ready, wr_pulses - w0);
    end
    do_read(AW'(5), 8'h05);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_addr_zero();
`ifdef URF_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
